// File: rtl/alu_pkg.sv
// Shared opcode, FSM state and flag definitions for the sequential ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_GT  = 4'd5,
    OP_GTU = 4'd6,
    OP_EQ  = 4'd7,
    OP_SLL = 4'd8,
    OP_SRL = 4'd9,
    OP_SRA = 4'd10,
    OP_MUL = 4'd11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic negative;
    logic overflow;
  } flags_t;

endpackage

// File: rtl/alu_core.sv
// Single-cycle ALU for opcodes 0-10; MUL and unused opcodes give 0 with Zero set.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [3:0]            sel,
  output logic [DATA_WIDTH-1:0] result,
  output flags_t                flags
);

  localparam int unsigned SHW = $clog2(DATA_WIDTH);
  localparam int unsigned MSB = DATA_WIDTH - 1;

  logic [DATA_WIDTH:0] sum;
  logic [DATA_WIDTH:0] diff;
  logic [SHW-1:0]      shamt;

  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};
  assign shamt = b[SHW-1:0];

  always_comb begin
    result = '0;
    flags  = '0;
    case (op_e'(sel))
      OP_ADD: begin
        result         = sum[DATA_WIDTH-1:0];
        flags.carry    = sum[DATA_WIDTH];
        flags.overflow = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        // Top bit of the widened difference is the unsigned borrow (A < B).
        result         = diff[DATA_WIDTH-1:0];
        flags.carry    = diff[DATA_WIDTH];
        flags.overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_GT:  result = DATA_WIDTH'($signed(a) > $signed(b));
      OP_GTU: result = DATA_WIDTH'(a > b);
      OP_EQ:  result = DATA_WIDTH'(a == b);
      OP_SLL: result = a << shamt;
      OP_SRL: result = a >> shamt;
      OP_SRA: result = $unsigned($signed(a) >>> shamt);
      default: result = '0;
    endcase
    flags.zero     = (result == '0);
    flags.negative = result[MSB];
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops via alu_core, MUL as a DATA_WIDTH-step shift-add.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [3:0]            ALU_Sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALU_Result,
  output logic                  Zero,
  output logic                  Carry,
  output logic                  Negative,
  output logic                  Overflow
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

  state_e state, state_next;

  logic                  accept;
  logic                  is_mul;
  logic                  last_step;
  logic [DATA_WIDTH-1:0] core_result;
  flags_t                core_flags;
  logic [DATA_WIDTH-1:0] mcand;
  logic [DATA_WIDTH-1:0] mplier;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] acc_next;
  logic [CNT_W-1:0]      step;
  logic [DATA_WIDTH-1:0] result_q;
  flags_t                flags_q;

  alu_core #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_core (
    .a     (A),
    .b     (B),
    .sel   (ALU_Sel),
    .result(core_result),
    .flags (core_flags)
  );

  assign accept    = in_valid && in_ready;
  assign is_mul    = (op_e'(ALU_Sel) == OP_MUL);
  assign last_step = (step == CNT_W'(DATA_WIDTH - 1));
  assign acc_next  = mplier[0] ? acc + mcand : acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = is_mul ? BUSY : DONE;
      BUSY:    if (last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Single-cycle ops register the core output directly from the ports at
  // acceptance; MUL captures operands and walks B one bit per BUSY cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      flags_q  <= '0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      step     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_mul) begin
              mcand  <= A;
              mplier <= B;
              acc    <= '0;
              step   <= '0;
            end else begin
              result_q <= core_result;
              flags_q  <= core_flags;
            end
          end
        end
        BUSY: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          step   <= step + 1'b1;
          if (last_step) begin
            result_q <= acc_next;
            flags_q  <= '{zero: (acc_next == '0), carry: 1'b0,
                          negative: acc_next[DATA_WIDTH-1], overflow: 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  assign ALU_Result = result_q;
  assign Zero       = flags_q.zero;
  assign Carry      = flags_q.carry;
  assign Negative   = flags_q.negative;
  assign Overflow   = flags_q.overflow;

endmodule

// File: tb/tb_alu_seq.sv
// Table-driven scoreboard bench for alu_seq, plus back-pressure, BUSY-ignore and abort sequences.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  ALU_Sel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALU_Result;
  logic        Zero, Carry, Negative, Overflow;

  alu_seq #(
    .DATA_WIDTH(32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .ALU_Sel   (ALU_Sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALU_Result(ALU_Result),
    .Zero      (Zero),
    .Carry     (Carry),
    .Negative  (Negative),
    .Overflow  (Overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  fl;   // {Zero, Carry, Negative, Overflow}
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  fl;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[20];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  bit   seen  = 1'b0;
  bit   mon_en = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail_now(string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endfunction

  // Scoreboard monitor: compares the queue head on every DONE cycle, latency on the first one.
  always @(negedge clk) begin
    #1;
    if (mon_en && out_valid) begin
      if (sb.size() == 0) begin
        fail_now("unexpected_output");
      end else begin
        chk("result", ALU_Result, sb[0].res);
        chk("flags", {Zero, Carry, Negative, Overflow}, sb[0].fl);
        chk("in_ready_in_done", in_ready, 1'b0);
        if (!seen) chk("latency", cyc - sb[0].acc_cyc, sb[0].lat);
        seen = 1'b1;
        if (out_ready) begin
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic op(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] res, input logic [3:0] fl, input int lat, input bit push);
    int w = 0;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      fail_now("in_ready_timeout");
      return;
    end
    if (push) sb.push_back('{res: res, fl: fl, lat: lat, acc_cyc: cyc});
    in_valid = 1'b1;
    ALU_Sel  = sel;
    A        = a;
    B        = b;
    @(negedge clk);
    in_valid = 1'b0;
    A        = $urandom;
    B        = $urandom;
    ALU_Sel  = 4'($urandom_range(0, 15));
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) fail_now("drain_timeout");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1100, 1};
    vecs[1]  = '{4'd1,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0001, 1};
    vecs[2]  = '{4'd0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0011, 1};
    vecs[3]  = '{4'd1,  32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF, 4'b0110, 1};
    vecs[4]  = '{4'd2,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 4'b0000, 1};
    vecs[5]  = '{4'd3,  32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 4'b0010, 1};
    vecs[6]  = '{4'd4,  32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'h0000_0000, 4'b1000, 1};
    vecs[7]  = '{4'd5,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0000, 1};
    vecs[8]  = '{4'd6,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 4'b1000, 1};
    vecs[9]  = '{4'd7,  32'h1234_5678, 32'h1234_5678, 32'h0000_0001, 4'b0000, 1};
    vecs[10] = '{4'd8,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 4'b0000, 1};
    vecs[11] = '{4'd9,  32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 4'b0000, 1};
    vecs[12] = '{4'd10, 32'h8000_0000, 32'h0000_0104, 32'hF800_0000, 4'b0010, 1};
    vecs[13] = '{4'd11, 32'h0001_0003, 32'h0001_0005, 32'h0008_000F, 4'b0000, 33};
    vecs[14] = '{4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0000, 33};
    vecs[15] = '{4'd12, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 4'b1000, 1};
    vecs[16] = '{4'd15, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 4'b1000, 1};
    vecs[17] = '{4'd11, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 4'b1000, 33};
    vecs[18] = '{4'd0,  32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 4'b1101, 1};
    vecs[19] = '{4'd1,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b1000, 1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    A         = '0;
    B         = '0;
    ALU_Sel   = '0;

    repeat (2) @(negedge clk);
    #1;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_result", ALU_Result, 32'h0);
    chk("reset_flags", {Zero, Carry, Negative, Overflow}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", in_ready, 1'b1);

    for (int i = 0; i < 20; i++)
      op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].fl, vecs[i].lat, 1'b1);
    drain();

    // Back-pressure: result held in DONE while out_ready is low.
    out_ready = 1'b0;
    op(4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0011, 1, 1'b1);
    repeat (5) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    #2;
    chk("bp_out_valid_after", out_valid, 1'b0);
    chk("bp_in_ready_after", in_ready, 1'b1);
    chk("hold_result_idle", ALU_Result, 32'h8000_0000);
    chk("hold_flags_idle", {Zero, Carry, Negative, Overflow}, 4'b0011);
    chk("bp_queue_empty", sb.size(), 0);

    // MUL with in_valid pulses during BUSY.
    op(4'd11, 32'h0001_0003, 32'h0001_0005, 32'h0008_000F, 4'b0000, 33, 1'b1);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      ALU_Sel  = 4'd0;
      A        = 32'h1;
      B        = 32'h2;
      #1;
      chk("busy_in_ready", in_ready, 1'b0);
      chk("busy_out_valid", out_valid, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
    end
    drain();

    // Abort mid-MUL: outputs clear immediately, nothing emitted later.
    op(4'd11, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A, 4'b0000, 33, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy_out_valid", out_valid, 1'b0);
    chk("abort_busy_result", ALU_Result, 32'h0);
    chk("abort_busy_flags", {Zero, Carry, Negative, Overflow}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_busy_in_ready", in_ready, 1'b1);
    op(4'd0, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 4'b0000, 1, 1'b1);
    op(4'd11, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A, 4'b0000, 33, 1'b1);
    drain();

    // Abort while DONE is stalled by back-pressure.
    mon_en    = 1'b0;
    out_ready = 1'b0;
    op(4'd3, 32'hF000_0000, 32'h0000_0001, 32'hF000_0001, 4'b0010, 1, 1'b0);
    @(negedge clk);
    #1;
    chk("stall_before_abort", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("abort_done_out_valid", out_valid, 1'b0);
    chk("abort_done_result", ALU_Result, 32'h0);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    mon_en    = 1'b1;
    op(4'd4, 32'h0000_00FF, 32'h0000_000F, 32'h0000_00F0, 4'b0000, 1, 1'b1);
    drain();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
